// File: rtl/pipe_risc_core.sv
// rtl/pipe_risc_core.sv - 5-stage pipelined RISC core with forwarding, load-use interlock and branch flush
`timescale 1ns/1ps
module pipe_risc_core #(
  parameter int XLEN  = 16,
  parameter int RF_AW = 5,
  parameter int PC_W  = 10,
  parameter int DA_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [DA_W-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             halted,
  output logic [15:0]      retired,
  input  logic [RF_AW-1:0] dbg_raddr,
  output logic [XLEN-1:0]  dbg_rdata
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;
  localparam int NREG = 1 << RF_AW;

  // fetch state
  logic [PC_W-1:0]  pc;
  logic             fetch_stop;

  // IF/ID
  logic             ifid_valid;
  logic [31:0]      ifid_instr;
  logic [PC_W-1:0]  ifid_pc;

  // ID/EX
  logic             idex_valid;
  logic [5:0]       idex_op;
  logic [RF_AW-1:0] idex_rs, idex_rt, idex_dst;
  logic             idex_wen;
  logic [XLEN-1:0]  idex_a, idex_b, idex_imm;
  logic [PC_W-1:0]  idex_pc;

  // EX/MEM
  logic             exmem_valid, exmem_wen, exmem_is_lw, exmem_is_sw, exmem_is_hlt;
  logic [RF_AW-1:0] exmem_dst;
  logic [XLEN-1:0]  exmem_res, exmem_sdata;

  // MEM/WB
  logic             memwb_valid, memwb_wen, memwb_is_hlt;
  logic [RF_AW-1:0] memwb_dst;
  logic [XLEN-1:0]  memwb_val;

  logic [XLEN-1:0]  rf [NREG];

  // decode / hazard nets
  logic [5:0]       id_op_raw, id_op;
  logic [RF_AW-1:0] id_rs, id_rt, id_rd, id_dst;
  logic             id_wen, id_chk_rt, id_is_hlt;
  logic [XLEN-1:0]  id_a, id_b, id_imm;
  logic             wb_we;
  logic [XLEN-1:0]  fwd_a, fwd_b, op_b, ex_res;
  logic             ex_use_imm, ex_taken, flush, ld_use, id_hlt;
  logic [PC_W-1:0]  br_target;

  assign imem_addr  = pc;
  assign dmem_addr  = exmem_res[DA_W-1:0];
  assign dmem_wdata = exmem_sdata;
  assign dmem_we    = rst_n && !halted && exmem_valid && exmem_is_sw;
  assign wb_we      = memwb_valid && memwb_wen;
  assign dbg_rdata  = (dbg_raddr == '0) ? '0 : rf[dbg_raddr];

  // decode the IF/ID word; unknown opcodes collapse to HLT, destination 0 means no write
  always_comb begin
    id_op_raw = ifid_instr[31:26];
    id_rs     = ifid_instr[21 +: RF_AW];
    id_rt     = ifid_instr[16 +: RF_AW];
    id_rd     = ifid_instr[11 +: RF_AW];
    id_imm    = XLEN'($signed(ifid_instr[15:0]));
    id_op     = OP_HLT;
    id_dst    = '0;
    id_chk_rt = 1'b0;
    case (id_op_raw)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_op     = id_op_raw;
        id_dst    = id_rd;
        id_chk_rt = 1'b1;
      end
      OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: begin
        id_op  = id_op_raw;
        id_dst = id_rt;
      end
      OP_SW: begin
        id_op     = id_op_raw;
        id_chk_rt = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: id_op = id_op_raw;
      default: id_op = OP_HLT;
    endcase
    id_wen    = (id_dst != '0);
    id_is_hlt = (id_op == OP_HLT);
  end

  // register read with bypass of the value being written back this cycle
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != '0) id_a = (wb_we && memwb_dst == id_rs) ? memwb_val : rf[id_rs];
    if (id_rt != '0) id_b = (wb_we && memwb_dst == id_rt) ? memwb_val : rf[id_rt];
  end

  // EX operand forwarding: younger non-load result in EX/MEM wins over MEM/WB
  always_comb begin
    fwd_a = idex_a;
    fwd_b = idex_b;
    if (idex_rs != '0) begin
      if (exmem_valid && exmem_wen && !exmem_is_lw && exmem_dst == idex_rs) fwd_a = exmem_res;
      else if (wb_we && memwb_dst == idex_rs) fwd_a = memwb_val;
    end
    if (idex_rt != '0) begin
      if (exmem_valid && exmem_wen && !exmem_is_lw && exmem_dst == idex_rt) fwd_b = exmem_res;
      else if (wb_we && memwb_dst == idex_rt) fwd_b = memwb_val;
    end
  end

  // ALU, branch resolution and hazard detection
  always_comb begin
    ex_use_imm = idex_op inside {OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI};
    op_b       = ex_use_imm ? idex_imm : fwd_b;
    ex_res     = '0;
    case (idex_op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_res = fwd_a + op_b;
      OP_SUB, OP_SUBI:               ex_res = fwd_a - op_b;
      OP_AND:                        ex_res = fwd_a & op_b;
      OP_OR:                         ex_res = fwd_a | op_b;
      OP_SLT, OP_SLTI:               ex_res = XLEN'($signed(fwd_a) < $signed(op_b));
      OP_MUL:                        ex_res = fwd_a * op_b;
      default:                       ex_res = '0;
    endcase
    ex_taken  = idex_valid && ((idex_op == OP_BEQZ && fwd_a == '0) ||
                               (idex_op == OP_BNEQZ && fwd_a != '0));
    br_target = idex_pc + PC_W'(1) + PC_W'(idex_imm);
    flush     = ex_taken;
    ld_use    = idex_valid && idex_op == OP_LW && ifid_valid &&
                (idex_rt == id_rs || (id_chk_rt && idex_rt == id_rt));
    id_hlt    = ifid_valid && id_is_hlt;
  end

  // PC and IF/ID: flush beats load-use stall, which beats halt freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      fetch_stop <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (!halted) begin
      if (flush) begin
        pc         <= br_target;
        ifid_valid <= 1'b0;
      end else if (!ld_use) begin
        if (id_hlt || fetch_stop) begin
          ifid_valid <= 1'b0;
          if (id_hlt) fetch_stop <= 1'b1;
        end else begin
          pc         <= pc + PC_W'(1);
          ifid_valid <= 1'b1;
          ifid_instr <= imem_rdata;
          ifid_pc    <= pc;
        end
      end
    end
  end

  // ID/EX register; a bubble is inserted on flush or load-use stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid <= 1'b0;
      idex_op    <= '0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_dst   <= '0;
      idex_wen   <= 1'b0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_pc    <= '0;
    end else if (!halted) begin
      idex_valid <= ifid_valid && !flush && !ld_use;
      idex_op    <= id_op;
      idex_rs    <= id_rs;
      idex_rt    <= id_rt;
      idex_dst   <= id_dst;
      idex_wen   <= id_wen;
      idex_a     <= id_a;
      idex_b     <= id_b;
      idex_imm   <= id_imm;
      idex_pc    <= ifid_pc;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_valid  <= 1'b0;
      exmem_wen    <= 1'b0;
      exmem_is_lw  <= 1'b0;
      exmem_is_sw  <= 1'b0;
      exmem_is_hlt <= 1'b0;
      exmem_dst    <= '0;
      exmem_res    <= '0;
      exmem_sdata  <= '0;
    end else if (!halted) begin
      exmem_valid  <= idex_valid;
      exmem_wen    <= idex_wen;
      exmem_is_lw  <= idex_op == OP_LW;
      exmem_is_sw  <= idex_op == OP_SW;
      exmem_is_hlt <= idex_op == OP_HLT;
      exmem_dst    <= idex_dst;
      exmem_res    <= ex_res;
      exmem_sdata  <= fwd_b;
    end
  end

  // MEM/WB register; loads capture the combinational read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_valid  <= 1'b0;
      memwb_wen    <= 1'b0;
      memwb_is_hlt <= 1'b0;
      memwb_dst    <= '0;
      memwb_val    <= '0;
    end else if (!halted) begin
      memwb_valid  <= exmem_valid;
      memwb_wen    <= exmem_wen;
      memwb_is_hlt <= exmem_is_hlt;
      memwb_dst    <= exmem_dst;
      memwb_val    <= exmem_is_lw ? dmem_rdata : exmem_res;
    end
  end

  // register file write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (!halted && wb_we) begin
      rf[memwb_dst] <= memwb_val;
    end
  end

  // retirement counter and sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
      halted  <= 1'b0;
    end else if (!halted && memwb_valid) begin
      retired <= retired + 16'd1;
      if (memwb_is_hlt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_risc_core.sv
// tb/tb_pipe_risc_core.sv - directed and random programs checked against an instruction-level model
`timescale 1ns/1ps
module tb_pipe_risc_core;

  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02, OR_ = 6'h03, SLT = 6'h04, MUL = 6'h05;
  localparam logic [5:0] LW = 6'h08, SW = 6'h09, ADDI = 6'h0A, SUBI = 6'h0B, SLTI = 6'h0C;
  localparam logic [5:0] BNEQZ = 6'h0D, BEQZ = 6'h0E;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic [15:0] dmem_rdata;
  logic        halted;
  logic [15:0] retired;
  logic [4:0]  dbg_raddr = '0;
  logic [15:0] dbg_rdata;

  logic [31:0] imem [1024];
  logic [15:0] dmem [1024];
  logic [15:0] dmem_init [1024];
  logic        load_req = 1'b0;

  logic [15:0] m_reg [32];
  int          m_retired = 0;
  logic [25:0] exp_stores [$];
  int          we_count = 0;
  int          checks = 0;
  int          errors = 0;

  pipe_risc_core #(.XLEN(16), .RF_AW(5), .PC_W(10), .DA_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .halted(halted), .retired(retired),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= dmem_init[i];
    end else if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // per-cycle compare: store stream and retirement count against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_we) begin
        we_count++;
        if (exp_stores.size() == 0) begin
          chk("store_unexpected", {6'd0, dmem_addr, dmem_wdata}, 32'hFFFF_FFFF);
        end else begin
          chk("store", {6'd0, dmem_addr, dmem_wdata}, {6'd0, exp_stores.pop_front()});
        end
      end
      chk("retired_bound", 32'(int'(retired) > m_retired), 32'd0);
      if (halted) chk("retired_at_halt", 32'(retired), 32'(m_retired));
    end
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = HLT_W;
  endtask

  // instruction-at-a-time interpreter of the current imem/dmem_init
  task automatic run_model();
    logic [15:0] mm [1024];
    logic [31:0] ins;
    logic [5:0]  op;
    logic [15:0] a, b, imm, sum, wv;
    int          rs, rt, rd, pc, npc, wd;
    logic        done;
    for (int i = 0; i < 1024; i++) mm[i] = dmem_init[i];
    for (int i = 0; i < 32; i++) m_reg[i] = 16'h0;
    exp_stores.delete();
    m_retired = 0;
    pc = 0;
    done = 1'b0;
    for (int step = 0; step < 20000 && !done; step++) begin
      ins = imem[pc];
      op  = ins[31:26];
      rs  = int'(ins[25:21]);
      rt  = int'(ins[20:16]);
      rd  = int'(ins[15:11]);
      imm = ins[15:0];
      a   = m_reg[rs];
      b   = m_reg[rt];
      sum = a + imm;
      wd  = 0;
      wv  = 16'h0;
      npc = (pc + 1) & 1023;
      m_retired++;
      case (op)
        ADD:   begin wd = rd; wv = a + b; end
        SUB:   begin wd = rd; wv = a - b; end
        AND_:  begin wd = rd; wv = a & b; end
        OR_:   begin wd = rd; wv = a | b; end
        SLT:   begin wd = rd; wv = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; end
        MUL:   begin wd = rd; wv = a * b; end
        LW:    begin wd = rt; wv = mm[sum[9:0]]; end
        SW:    begin mm[sum[9:0]] = b; exp_stores.push_back({sum[9:0], b}); end
        ADDI:  begin wd = rt; wv = a + imm; end
        SUBI:  begin wd = rt; wv = a - imm; end
        SLTI:  begin wd = rt; wv = ($signed(a) < $signed(imm)) ? 16'd1 : 16'd0; end
        BNEQZ: if (a != 16'h0) npc = (pc + 1 + int'($signed(imm))) & 1023;
        BEQZ:  if (a == 16'h0) npc = (pc + 1 + int'($signed(imm))) & 1023;
        default: done = 1'b1;
      endcase
      if (wd != 0) m_reg[wd] = wv;
      pc = npc;
    end
  endtask

  task automatic rd_reg(input int r, output logic [15:0] v);
    dbg_raddr = 5'(r);
    #1;
    v = dbg_rdata;
  endtask

  // assert reset, check cleared state, prepare model and memory, release
  task automatic start_prog(input string name);
    logic [15:0] v;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({name, "_rst_halted"}, 32'(halted), 32'd0);
    chk({name, "_rst_retired"}, 32'(retired), 32'd0);
    chk({name, "_rst_pc"}, 32'(imem_addr), 32'd0);
    chk({name, "_rst_we"}, 32'(dmem_we), 32'd0);
    for (int r = 0; r < 32; r++) begin
      rd_reg(r, v);
      chk($sformatf("%s_rst_r%0d", name, r), 32'(v), 32'd0);
    end
    run_model();
    we_count = 0;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input string name, input int budget, output int cycles);
    logic [15:0] v;
    start_prog(name);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk({name, "_halted"}, 32'(halted), 32'd1);
    chk({name, "_retired"}, 32'(retired), 32'(m_retired));
    chk({name, "_stores_left"}, 32'(exp_stores.size()), 32'd0);
    for (int r = 0; r < 32; r++) begin
      rd_reg(r, v);
      chk($sformatf("%s_r%0d", name, r), 32'(v), 32'(m_reg[r]));
    end
  endtask

  task automatic gen_random_prog(input int len);
    int kind, rs, rt, rd;
    logic [5:0] op;
    clear_imem();
    for (int i = 0; i < len; i++) begin
      kind = int'($urandom_range(0, 9));
      rs = int'($urandom_range(0, 7));
      rt = int'($urandom_range(0, 7));
      rd = int'($urandom_range(0, 7));
      case (kind)
        0, 1, 2, 3: begin
          op = 6'($urandom_range(0, 5));
          imem[i] = rr(op, rd, rs, rt);
        end
        4, 5: begin
          op = 6'($urandom_range(10, 12));
          imem[i] = ri(op, rt, rs, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 4)) - 2);
        end
        6: imem[i] = ri(LW, rt, ($urandom_range(0, 1) != 0) ? 0 : rs, int'($urandom_range(0, 31)));
        7: imem[i] = ri(SW, rt, ($urandom_range(0, 1) != 0) ? 0 : rs, int'($urandom_range(0, 31)));
        8: imem[i] = ri(($urandom_range(0, 1) != 0) ? BEQZ : BNEQZ, 0, rs, int'($urandom_range(0, 3)));
        default: imem[i] = ri(ADDI, rt, 0, int'($urandom_range(0, 2)));
      endcase
    end
    imem[len] = HLT_W;
  endtask

  initial begin
    int cyc;
    logic [15:0] v;
    for (int i = 0; i < 1024; i++) dmem_init[i] = 16'h0;

    // 1: straight-line ALU, no stalls
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, 5);
    imem[1] = ri(ADDI, 2, 0, 7);
    imem[2] = rr(ADD, 3, 1, 2);
    imem[3] = HLT_W;
    run_prog("t1", 200, cyc);
    chk("t1_cycles", 32'(cyc), 32'd8);
    rd_reg(3, v);
    chk("t1_r3", 32'(v), 32'd12);
    chk("t1_retired_lit", 32'(retired), 32'd4);
    chk("t1_model_retired", 32'(m_retired), 32'd4);

    // 2: back-to-back dependencies
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, 3);
    imem[1] = rr(ADD, 1, 1, 1);
    imem[2] = rr(ADD, 1, 1, 1);
    run_prog("t2", 200, cyc);
    chk("t2_cycles", 32'(cyc), 32'd8);
    rd_reg(1, v);
    chk("t2_r1", 32'(v), 32'd12);

    // 3: store, load, load-use stall
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, 9);
    imem[1] = ri(SW, 1, 0, 4);
    imem[2] = ri(LW, 2, 0, 4);
    imem[3] = rr(ADD, 3, 2, 2);
    run_prog("t3", 200, cyc);
    chk("t3_cycles", 32'(cyc), 32'd10);
    rd_reg(3, v);
    chk("t3_r3", 32'(v), 32'd18);
    chk("t3_we_count", 32'(we_count), 32'd1);
    chk("t3_mem4", 32'(dmem[4]), 32'd9);

    // 4: loop with taken-branch flush
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, 3);
    imem[1] = ri(SUBI, 1, 1, 1);
    imem[2] = ri(BNEQZ, 0, 1, -2);
    imem[3] = ri(ADDI, 5, 5, 1);
    run_prog("t4", 300, cyc);
    chk("t4_cycles", 32'(cyc), 32'd17);
    rd_reg(1, v);
    chk("t4_r1", 32'(v), 32'd0);
    rd_reg(5, v);
    chk("t4_r5", 32'(v), 32'd1);
    chk("t4_retired_lit", 32'(retired), 32'd9);
    chk("t4_model_retired", 32'(m_retired), 32'd9);

    // 5: signed compare, multiply wrap, r0 write discard
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, -1);
    imem[1] = ri(ADDI, 2, 0, 1);
    imem[2] = rr(SLT, 3, 1, 2);
    imem[3] = ri(ADDI, 4, 0, 16'h0100);
    imem[4] = rr(MUL, 5, 4, 4);
    imem[5] = ri(ADDI, 0, 0, 7);
    imem[6] = rr(ADD, 6, 0, 0);
    run_prog("t5", 200, cyc);
    rd_reg(3, v);
    chk("t5_slt", 32'(v), 32'd1);
    rd_reg(5, v);
    chk("t5_mul", 32'(v), 32'd0);
    rd_reg(0, v);
    chk("t5_r0", 32'(v), 32'd0);
    rd_reg(6, v);
    chk("t5_r6", 32'(v), 32'd0);

    // 6a: undefined opcode halts
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, 5);
    imem[1] = 32'h8000_0000;
    imem[2] = ri(ADDI, 2, 0, 9);
    run_prog("t6", 200, cyc);
    rd_reg(1, v);
    chk("t6_r1", 32'(v), 32'd5);
    rd_reg(2, v);
    chk("t6_r2", 32'(v), 32'd0);
    chk("t6_retired_lit", 32'(retired), 32'd2);

    // 6b: reset pulse mid-program, then clean restart
    clear_imem();
    imem[0] = ri(ADDI, 1, 0, 40);
    imem[1] = ri(SUBI, 1, 1, 1);
    imem[2] = ri(BNEQZ, 0, 1, -2);
    imem[3] = ri(ADDI, 5, 5, 1);
    start_prog("t6b_first");
    repeat (30) @(posedge clk);
    #1;
    chk("t6b_running", 32'(retired != 16'd0 && !halted), 32'd1);
    run_prog("t6b", 1000, cyc);
    chk("t6b_retired_lit", 32'(retired), 32'd83);

    // random programs
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 1024; i++) dmem_init[i] = 16'($urandom);
      gen_random_prog(30);
      run_prog($sformatf("rnd%0d", p), 1000, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
